mem_store_buffer: RTL and testbench
===================================

// Module: mem_store_buffer
// PURPOSE
//  Write-side counterpart of the WB load-extraction path: takes committed stores from MEM,
//  converts size/offset into byte strobes and lane-replicated write data, queues them in
//  a DEPTH-entry FIFO and drains them one at a time to the data-RAM bus via req/addr_ok/data_ok.
//  Also flags misaligned stores and reports load/store word conflicts so the hazard unit can stall loads.
// PARAMETERS
//  DEPTH   4   store-buffer entries; power of 2, >=2
//  ADDR_W  32  address width (`ADDR_BUS)
//  DATA_W  32  data width (`DATA_BUS)
// PORTS
//  clk            in   1   clock, rising edge
//  resetn         in   1   asynchronous active-low reset
//  st_valid       in   1   store request from MEM
//  st_addr        in   32  byte address
//  st_data        in   32  store data, right-aligned (rt value)
//  st_size        in   2   0=byte 1=half 2=word 3=illegal
//  st_ready       out  1   buffer can accept (count<DEPTH)
//  st_addr_err    out  1   misaligned/illegal store this cycle (comb., AdES)
//  ld_addr        in   32  address of load in MEM
//  ld_conflict    out  1   queued/in-flight entry has same word as ld_addr (comb.)
//  sb_empty       out  1   no entries and no bus transaction pending
//  data_req       out  1   bus request
//  data_wr        out  1   constant 1 (write)
//  data_size      out  2   size of head entry
//  data_addr      out  32  head address
//  data_wstrb     out  4   head byte strobes (`MEM_SEL_BUS)
//  data_wdata     out  32  head write data
//  data_addr_ok   in   1   bus accepted address
//  data_data_ok   in   1   bus completed write
// BEHAVIOUR
//  Reset: count=0, rd/wr ptr=0, FSM=IDLE, data_req=0, sb_empty=1, st_ready=1; bus outputs 0.
//  Alignment (comb. on st_*): byte: wstrb=4'b0001<<addr[1:0], wdata={4{data[7:0]}};
//   half: wstrb=addr[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}; word: wstrb=4'b1111, wdata=data.
//  st_addr_err=st_valid & (size==3 | (half & addr[0]) | (word & addr[1:0]!=0)).
//  Enqueue when st_valid & st_ready & !st_addr_err; erroneous store never enqueued.
//  st_ready from registered count only: full buffer refuses even if a pop occurs that cycle.
//  Enqueue+pop same cycle: count unchanged; pointers wrap modulo DEPTH.
//  FSM (one outstanding transaction):
//   IDLE: count>0 -> REQ (registered; first data_req at N+1 after enqueue at edge N).
//   REQ : data_req=1, head fields held stable; addr_ok&data_ok -> pop, IDLE;
//         addr_ok only -> WAIT; else stay.
//   WAIT: data_req=0, head fields held; data_ok -> pop, IDLE.
//  data_ok in IDLE/REQ-without-addr_ok ignored.
//  ld_conflict=OR over valid entries (head included while REQ/WAIT) of addr[31:2]==ld_addr[31:2].
//  sb_empty=(count==0)&(FSM==IDLE).
//  Reset mid-operation: buffer contents discarded, in-flight write abandoned, data_req drops
//   asynchronously; bus slave is reset together with this block.
// TESTING
//  SB h1 addr 0x0000_0103, data 0x1234_56AB -> wstrb 4'b1000, wdata 0xABAB_ABAB, 1 bus write.
//  SH addr 0x102, data 0xBEEF; SW addr 0x104 -> wstrb 1100/wdata 0xBEEF_BEEF then 1111, FIFO order.
//  SH addr 0x101 / SW addr 0x106 / size=3 -> st_addr_err=1, count unchanged, no data_req.
//  5 back-to-back SW, addr_ok held low -> st_ready=0 after 4th, 5th stalls until first data_ok.
//  addr_ok&data_ok same cycle vs. addr_ok then data_ok 3 cycles later -> one pop each, req drops.
//  Queued SW 0x200, ld_addr 0x203 -> ld_conflict=1; ld_addr 0x204 -> 0; resetn low mid-WAIT -> all reset values.

Source files
------------

// File: rtl/mem_store_buffer_if.sv
// Data-RAM write bus between the store buffer (master) and the memory-side slave.
// A transfer is offered while data_req=1 with the data_* fields held stable. It
// is accepted on any cycle with data_req & data_addr_ok, and completes on a later
// or the same cycle with data_data_ok. Only one transfer is outstanding at a time.
interface mem_store_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_wstrb;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/mem_store_buffer.sv
// Store buffer: aligns committed stores into byte strobes and replicated lanes,
// queues them in a small FIFO and drains them one at a time to the data-RAM bus.
module mem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [1:0]        st_size,
  output logic              st_ready,
  output logic              st_addr_err,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_conflict,
  output logic              sb_empty,
  output logic [1:0]        dbg_state,
  mem_store_buffer_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [ADDR_W-1:0] addr_d  [DEPTH];
  logic [1:0]        size_q  [DEPTH];
  logic [1:0]        size_d  [DEPTH];
  logic [3:0]        wstrb_q [DEPTH];
  logic [3:0]        wstrb_d [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];
  logic [DATA_W-1:0] wdata_d [DEPTH];

  logic [3:0]        st_wstrb;
  logic [DATA_W-1:0] st_wdata;
  logic              push, pop, busy;
  logic [PW-1:0]     conf_ofs;
  logic              ld_unused;

  // Byte offset within the word only matters for strobe placement.
  always_comb begin
    st_wstrb    = 4'b0000;
    st_wdata    = '0;
    st_addr_err = 1'b0;
    case (st_size)
      2'd0: begin
        st_wstrb = 4'b0001 << st_addr[1:0];
        st_wdata = {4{st_data[7:0]}};
      end
      2'd1: begin
        st_wstrb    = st_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata    = {2{st_data[15:0]}};
        st_addr_err = st_valid & st_addr[0];
      end
      2'd2: begin
        st_wstrb    = 4'b1111;
        st_wdata    = st_data;
        st_addr_err = st_valid & (st_addr[1:0] != 2'b00);
      end
      default: st_addr_err = st_valid;
    endcase
  end

  // Readiness comes from the registered count only, so a pop never frees a slot early.
  assign st_ready = (count_q < FULL);
  assign push     = st_valid & st_ready & ~st_addr_err;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    size_d   = size_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    pop      = 1'b0;

    case (state_q)
      ST_IDLE: if (count_q != '0) state_d = ST_REQ;
      ST_REQ: begin
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            pop     = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.data_data_ok) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      addr_d[wr_ptr_q]  = st_addr;
      size_d[wr_ptr_q]  = st_size;
      wstrb_d[wr_ptr_q] = st_wstrb;
      wdata_d[wr_ptr_q] = st_wdata;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        size_q[i]  <= '0;
        wstrb_q[i] <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
    end
  end

  // An entry is live when its distance from the head is below the count; the
  // in-flight head stays live until its write completes.
  always_comb begin
    ld_conflict = 1'b0;
    conf_ofs    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      conf_ofs = PW'(i) - rd_ptr_q;
      if (({1'b0, conf_ofs} < count_q) &&
          (addr_q[i][ADDR_W-1:2] == ld_addr[ADDR_W-1:2]))
        ld_conflict = 1'b1;
    end
  end

  assign ld_unused = ^ld_addr[1:0];

  assign busy           = (state_q != ST_IDLE);
  assign bus.data_req   = (state_q == ST_REQ);
  assign bus.data_wr    = 1'b1;
  assign bus.data_addr  = busy ? addr_q[rd_ptr_q]  : '0;
  assign bus.data_size  = busy ? size_q[rd_ptr_q]  : 2'b00;
  assign bus.data_wstrb = busy ? wstrb_q[rd_ptr_q] : 4'b0000;
  assign bus.data_wdata = busy ? wdata_q[rd_ptr_q] : '0;

  assign sb_empty  = (count_q == '0) && (state_q == ST_IDLE);
  assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_store_buffer.sv
// Randomised scoreboard bench for mem_store_buffer: a store driver, a bus-slave
// monitor that checks every accepted write against a queue of expected writes.
module tb_mem_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        st_valid;
  logic [31:0] st_addr, st_data, ld_addr;
  logic [1:0]  st_size;
  logic        st_ready, st_addr_err, ld_conflict, sb_empty;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mem_store_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .st_ready(st_ready), .st_addr_err(st_addr_err),
    .ld_addr(ld_addr), .ld_conflict(ld_conflict), .sb_empty(sb_empty),
    .dbg_state(dbg_state), .bus(bus)
  );

  // Expected write packed as {addr[31:0], size[1:0], wstrb[3:0], wdata[31:0]}.
  logic [69:0] exp_q[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_push  = 0;
  int          n_pop   = 0;
  logic        push_now = 1'b0;
  int          phase = 0;
  logic        exp_req = 1'b0;
  logic        inflight_v = 1'b0;
  logic [31:0] inflight_addr = '0;
  int          slave_mode = 0;
  logic        mon_run = 1'b0;
  logic [69:0] mon_e;
  logic        mon_go, mon_done, mon_nxt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_strb(input logic [1:0] ofs, input logic [1:0] sz);
    int bytes = 1 << sz;
    return 4'(((1 << bytes) - 1) << ofs);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] sz);
    int bytes = 1 << sz;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % bytes) +: 8];
    return r;
  endfunction

  function automatic logic ref_err(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || ((int'(a[1:0]) % (1 << sz)) != 0);
  endfunction

  function automatic logic ref_conflict(input logic [31:0] la);
    logic r = inflight_v && (inflight_addr[31:2] == la[31:2]);
    foreach (exp_q[i]) if (exp_q[i][69:40] == la[31:2]) r = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] rnd_ld();
    return 32'h100 + 32'($urandom_range(0, 63));
  endfunction

  // One clock of store-side stimulus; checks status outputs against the model first.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic [31:0] la, output logic acc);
    int   cnt;
    logic err;
    @(negedge clk);
    cnt = n_push - n_pop;
    chk("st_ready", 32'(st_ready), 32'(cnt < DEPTH));
    chk("sb_empty", 32'(sb_empty), 32'(cnt == 0));
    chk("ld_conflict", 32'(ld_conflict), 32'(ref_conflict(ld_addr)));
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_size  = sz;
    ld_addr  = la;
    err = v && ref_err(a, sz);
    acc = v && !err && (cnt < DEPTH);
    push_now = acc;
    if (acc) begin
      exp_q.push_back({a, sz, ref_strb(a[1:0], sz), ref_wdata(d, sz)});
      n_push++;
    end
    #1;
    chk("st_addr_err", 32'(st_addr_err), 32'(err));
  endtask

  task automatic idle(input logic [31:0] la);
    logic acc;
    step(1'b0, 32'h0, 32'h0, 2'd0, la, acc);
  endtask

  task automatic drain();
    int k = 0;
    while (((n_push - n_pop) != 0 || phase != 0) && k < 500) begin
      idle(rnd_ld());
      k++;
    end
    chk("drain_timeout", 32'(k < 500), 32'd1);
  endtask

  task automatic check_reset_values(input logic [31:0] la);
    chk("rst_data_req", 32'(bus.data_req), 32'd0);
    chk("rst_sb_empty", 32'(sb_empty), 32'd1);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_data_addr", bus.data_addr, 32'd0);
    chk("rst_data_wstrb", 32'(bus.data_wstrb), 32'd0);
    chk("rst_data_wdata", bus.data_wdata, 32'd0);
    chk("rst_data_size", 32'(bus.data_size), 32'd0);
    chk("rst_ld_conflict", 32'(ld_conflict), 32'd0);
    chk("rst_st_addr_err", 32'(st_addr_err), 32'd0);
    chk("rst_ld_addr_used", la, ld_addr);
  endtask

  // Bus slave + monitor: acts #1 after each falling edge, pops expected writes on accept.
  always begin
    @(negedge clk);
    #1;
    if (!mon_run) begin
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;
    end else begin
      chk("data_req", 32'(bus.data_req), 32'(exp_req));
      chk("data_wr", 32'(bus.data_wr), 32'd1);
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;
      mon_nxt = 1'b0;
      if (phase == 1) begin
        chk("wait_addr_held", bus.data_addr, inflight_addr);
        if (slave_mode == 0 && $urandom_range(0, 2) == 0) begin
          bus.data_data_ok = 1'b1;
          n_pop++;
          phase = 0;
          inflight_v = 1'b0;
        end
      end else if (exp_req) begin
        mon_go = (slave_mode == 2) || (slave_mode == 0 && $urandom_range(0, 2) != 0);
        if (mon_go && exp_q.size() != 0) begin
          bus.data_addr_ok = 1'b1;
          mon_e = exp_q.pop_front();
          chk("wr_addr", bus.data_addr, mon_e[69:38]);
          chk("wr_size", 32'(bus.data_size), 32'(mon_e[37:36]));
          chk("wr_wstrb", 32'(bus.data_wstrb), 32'(mon_e[35:32]));
          chk("wr_wdata", bus.data_wdata, mon_e[31:0]);
          mon_done = (slave_mode == 0) && ($urandom_range(0, 1) == 1);
          if (mon_done) begin
            bus.data_data_ok = 1'b1;
            n_pop++;
          end else begin
            phase = 1;
            inflight_v = 1'b1;
            inflight_addr = mon_e[69:38];
          end
        end else begin
          mon_nxt = 1'b1;
          bus.data_data_ok = (slave_mode == 0) && ($urandom_range(0, 3) == 0);
        end
      end else begin
        bus.data_data_ok = (slave_mode == 0) && ($urandom_range(0, 3) == 0);
        mon_nxt = (n_push - (push_now ? 1 : 0) - n_pop) > 0;
      end
      exp_req = mon_nxt;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [31:0] a, d;
    logic [1:0]  sz;
    int          k, r;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; ld_addr = 32'h100;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_reset_values(32'h100);
    @(negedge clk);
    resetn = 1'b1;
    mon_run = 1'b1;

    step(1'b1, 32'h0000_0103, 32'h1234_56AB, 2'd0, 32'h0, acc);
    drain();
    step(1'b1, 32'h0000_0102, 32'h0000_BEEF, 2'd1, 32'h0, acc);
    step(1'b1, 32'h0000_0104, 32'hCAFE_F00D, 2'd2, 32'h0, acc);
    drain();

    step(1'b1, 32'h0000_0101, 32'h1111_2222, 2'd1, 32'h0, acc);
    step(1'b1, 32'h0000_0106, 32'h3333_4444, 2'd2, 32'h0, acc);
    step(1'b1, 32'h0000_0108, 32'h5555_6666, 2'd3, 32'h0, acc);
    repeat (3) idle(32'h0);

    slave_mode = 1;
    for (int i = 0; i < 4; i++) step(1'b1, 32'h180 + 32'(4 * i), $urandom, 2'd2, rnd_ld(), acc);
    d = $urandom;
    for (int i = 0; i < 3; i++) step(1'b1, 32'h190, d, 2'd2, rnd_ld(), acc);
    slave_mode = 0;
    k = 0;
    acc = 1'b0;
    while (!acc && k < 100) begin
      step(1'b1, 32'h190, d, 2'd2, rnd_ld(), acc);
      k++;
    end
    chk("fifth_store_accepted", 32'(acc), 32'd1);
    drain();

    slave_mode = 1;
    step(1'b1, 32'h0000_0200, 32'hA5A5_5A5A, 2'd2, 32'h0, acc);
    idle(32'h0000_0203);
    idle(32'h0000_0204);
    idle(32'h0000_01FC);
    idle(32'h0000_0200);
    slave_mode = 0;
    drain();

    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      sz = (r == 9) ? 2'd3 : 2'(r % 3);
      a  = 32'h100 + 32'($urandom_range(0, 63));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~(32'((1 << sz) - 1));
      step(1'($urandom_range(0, 3) != 0), a, $urandom, sz, rnd_ld(), acc);
    end
    drain();

    slave_mode = 2;
    step(1'b1, 32'h0000_0300, 32'h0BAD_F00D, 2'd2, 32'h0, acc);
    k = 0;
    while (!inflight_v && k < 20) begin
      idle(32'h0);
      k++;
    end
    chk("reach_wait_timeout", 32'(inflight_v), 32'd1);
    idle(32'h0000_0300);
    @(negedge clk);
    mon_run  = 1'b0;
    st_valid = 1'b0;
    ld_addr  = 32'h0000_0300;
    resetn   = 1'b0;
    #2;
    check_reset_values(32'h0000_0300);
    exp_q.delete();
    n_push = 0; n_pop = 0; push_now = 1'b0;
    phase = 0; exp_req = 1'b0; inflight_v = 1'b0;
    slave_mode = 0;
    @(negedge clk);
    resetn  = 1'b1;
    mon_run = 1'b1;
    step(1'b1, 32'h0000_0304, 32'h0102_0304, 2'd2, 32'h0, acc);
    step(1'b1, 32'h0000_0301, 32'h0000_00C3, 2'd0, 32'h0000_0300, acc);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
